// File: rtl/i2c_bus_observer.sv
// Passive I2C front end: synchronises and deglitches SCL/SDA, decodes START/RSTART/STOP
// and bytes with their ACK bit, and queues one event record per bus event in a FWFT FIFO.
module i2c_bus_observer #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       evt_valid_o,
  input  logic       evt_ready_i,
  output logic [1:0] evt_type_o,
  output logic [7:0] evt_data_o,
  output logic       evt_ack_o,
  output logic       evt_first_o,
  output logic       evt_partial_o,
  output logic       busy_o,
  output logic       overflow_o,
  input  logic       clr_overflow_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FILTER_LEN + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  localparam logic [1:0] EV_START  = 2'd0;
  localparam logic [1:0] EV_RSTART = 2'd1;
  localparam logic [1:0] EV_STOP   = 2'd2;
  localparam logic [1:0] EV_BYTE   = 2'd3;

  // Line index 0 is SCL, 1 is SDA.
  logic [SYNC_STAGES-1:0] r_sync [2];
  logic [1:0]             w_raw;
  logic [1:0]             w_synced;
  logic [1:0]             r_filt;
  logic [1:0]             r_filt_d;
  logic [CW-1:0]          r_fcnt [2];

  assign w_raw = {sda_i, scl_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      assign w_synced[gi] = r_sync[gi][SYNC_STAGES-1];

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_sync[gi]   <= '1;
          r_filt[gi]   <= 1'b1;
          r_filt_d[gi] <= 1'b1;
          r_fcnt[gi]   <= '0;
        end else begin
          r_sync[gi]   <= {r_sync[gi][SYNC_STAGES-2:0], w_raw[gi]};
          r_filt_d[gi] <= r_filt[gi];
          if (w_synced[gi] != r_filt[gi]) begin
            if (r_fcnt[gi] == CW'(FILTER_LEN - 1)) begin
              r_filt[gi] <= w_synced[gi];
              r_fcnt[gi] <= '0;
            end else begin
              r_fcnt[gi] <= r_fcnt[gi] + 1'b1;
            end
          end else begin
            r_fcnt[gi] <= '0;
          end
        end
      end
    end
  endgenerate

  logic [CW-1:0] r_arm_cnt;
  logic          r_armed;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_arm_cnt <= '0;
      r_armed   <= 1'b0;
    end else if (!r_armed) begin
      if (&w_synced) begin
        if (r_arm_cnt == CW'(FILTER_LEN - 1)) r_armed <= 1'b1;
        else r_arm_cnt <= r_arm_cnt + 1'b1;
      end else begin
        r_arm_cnt <= '0;
      end
    end
  end

  logic w_scl_edge, w_sda_edge, w_scl_rise, w_scl_stable_hi, w_sda_fall;
  assign w_scl_edge      = r_filt[0] ^ r_filt_d[0];
  assign w_sda_edge      = r_filt[1] ^ r_filt_d[1];
  assign w_scl_rise      = w_scl_edge & r_filt[0];
  assign w_scl_stable_hi = r_filt[0] & ~w_scl_edge;
  assign w_sda_fall      = w_sda_edge & ~r_filt[1];

  logic [0:0]  r_state;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_first;
  logic        r_push;
  logic [12:0] r_push_rec;   // {type, data, ack, first, partial}

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_first    <= 1'b0;
      r_push     <= 1'b0;
      r_push_rec <= '0;
    end else begin
      r_push <= 1'b0;
      if (r_armed) begin
        if (w_scl_stable_hi && w_sda_edge) begin
          if (w_sda_fall) begin
            r_push     <= 1'b1;
            r_push_rec <= {(r_state == S_SHIFT) ? EV_RSTART : EV_START, 8'h00, 1'b0, 1'b0,
                           (r_state == S_SHIFT) && (r_bit_cnt != 4'd0)};
            r_state    <= S_SHIFT;
            r_bit_cnt  <= '0;
            r_first    <= 1'b1;
          end else if (r_state == S_SHIFT) begin
            r_push     <= 1'b1;
            r_push_rec <= {EV_STOP, 8'h00, 1'b0, 1'b0, r_bit_cnt != 4'd0};
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_first    <= 1'b0;
          end
        end else if (w_scl_rise && (r_state == S_SHIFT)) begin
          if (r_bit_cnt != 4'd8) begin
            r_shift   <= {r_shift[6:0], r_filt[1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end else begin
            r_push     <= 1'b1;
            r_push_rec <= {EV_BYTE, r_shift, ~r_filt[1], r_first, 1'b0};
            r_bit_cnt  <= '0;
            r_first    <= 1'b0;
          end
        end
      end
    end
  end

  assign busy_o = (r_state == S_SHIFT);

  logic [12:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic          w_valid, w_full, w_pop, w_wr, w_drop;
  logic [12:0]   w_head;

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop   = w_valid && evt_ready_i;
  assign w_wr    = r_push && (!w_full || w_pop);
  assign w_drop  = r_push && w_full && !w_pop;

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_push_rec;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);
      if (w_drop) r_overflow <= 1'b1;
      else if (clr_overflow_i) r_overflow <= 1'b0;
    end
  end

  assign w_head        = w_valid ? r_mem[r_rd_ptr] : 13'd0;
  assign evt_valid_o   = w_valid;
  assign evt_type_o    = w_head[12:11];
  assign evt_data_o    = w_head[10:3];
  assign evt_ack_o     = w_head[2];
  assign evt_first_o   = w_head[1];
  assign evt_partial_o = w_head[0];
  assign overflow_o    = r_overflow;

endmodule
